// File: rtl/cpu_run_controller_if.sv
// Host/core-facing signal bundle of the run controller.
// master = bench/debug host and core snoop side, slave = cpu_run_controller.
interface cpu_run_controller_if #(
  parameter int PC_WIDTH  = 64,
  parameter int IC_WIDTH  = 32,
  parameter int CNT_WIDTH = 32
);
  // START and STEP are single-cycle pulses sampled on the rising edge; ABORT and
  // STEP_MODE are levels. All controller outputs are registered.
  logic                 START;
  logic                 ABORT;
  logic                 STEP_MODE;
  logic                 STEP;
  logic [PC_WIDTH-1:0]  PC;
  logic [IC_WIDTH-1:0]  IC;
  logic                 CPU_EN;
  logic                 CPU_RST_N;
  logic [CNT_WIDTH-1:0] CYCLE_COUNT;
  logic                 DONE;
  logic [2:0]           STATUS;
  logic [2:0]           dbg_state;

  modport master (
    output START, ABORT, STEP_MODE, STEP, PC, IC,
    input  CPU_EN, CPU_RST_N, CYCLE_COUNT, DONE, STATUS, dbg_state
  );

  modport slave (
    input  START, ABORT, STEP_MODE, STEP, PC, IC,
    output CPU_EN, CPU_RST_N, CYCLE_COUNT, DONE, STATUS, dbg_state
  );
endinterface

// File: rtl/cpu_run_controller.sv
// Run controller for the pipelined LEGv8 core: sequences core reset, gates the
// core clock enable (free-run / single-step) and ends a run on halt, budget, hang or abort.
module cpu_run_controller #(
  parameter int                  PC_WIDTH    = 64,
  parameter int                  IC_WIDTH    = 32,
  parameter int                  CNT_WIDTH   = 32,
  parameter int                  MAX_CYCLES  = 5,
  parameter logic [IC_WIDTH-1:0] HALT_OPCODE = 32'hD4400000,
  parameter int                  STALL_LIMIT = 8,
  parameter int                  RST_CYCLES  = 2
) (
  input logic                  CLOCK,
  input logic                  RESET_N,
  cpu_run_controller_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RST_HOLD  = 3'd1,
    S_RUN       = 3'd2,
    S_STEP_WAIT = 3'd3,
    S_STEP_EXEC = 3'd4,
    S_DONE      = 3'd5
  } state_e;

  localparam int RCW = $clog2(RST_CYCLES + 1);
  localparam int SCW = $clog2(STALL_LIMIT + 1) + 1;

  localparam logic [2:0] ST_NONE  = 3'd0;
  localparam logic [2:0] ST_HALT  = 3'd1;
  localparam logic [2:0] ST_MAX   = 3'd2;
  localparam logic [2:0] ST_HANG  = 3'd3;
  localparam logic [2:0] ST_ABORT = 3'd4;

  state_e               state_q, state_d;
  logic [RCW-1:0]       rst_cnt_q, rst_cnt_d;
  logic [CNT_WIDTH-1:0] cycle_count_q, cycle_count_d;
  logic [SCW-1:0]       stall_cnt_q, stall_cnt_d;
  logic [PC_WIDTH-1:0]  prev_pc_q, prev_pc_d;
  logic                 prev_valid_q, prev_valid_d;
  logic [2:0]           status_q, status_d;
  logic                 cpu_en_q, cpu_en_d;
  logic                 cpu_rst_n_q, cpu_rst_n_d;
  logic                 done_q, done_d;

  logic                 enabled;
  logic                 in_run;
  logic                 pc_repeat;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic [SCW-1:0]       stall_inc;
  logic                 is_halt, is_max, is_hang, is_abort;

  // cpu_en_q is aligned with state_q, so "enabled cycle" is simply CPU_EN high.
  assign enabled  = cpu_en_q;
  assign in_run   = (state_q == S_RUN) || (state_q == S_STEP_WAIT) || (state_q == S_STEP_EXEC);

  // The first enabled cycle of a run has no previous PC to compare against.
  assign pc_repeat = prev_valid_q && (bus.PC == prev_pc_q);
  assign cnt_inc   = (&cycle_count_q) ? cycle_count_q : cycle_count_q + CNT_WIDTH'(1);
  assign stall_inc = !pc_repeat ? '0 :
                     (&stall_cnt_q) ? stall_cnt_q : stall_cnt_q + SCW'(1);

  assign is_halt  = (bus.IC == HALT_OPCODE);
  assign is_max   = (MAX_CYCLES != 0) && (cnt_inc == CNT_WIDTH'(MAX_CYCLES));
  assign is_hang  = (STALL_LIMIT != 0) && (stall_inc == SCW'(STALL_LIMIT));
  assign is_abort = bus.ABORT && in_run;

  always_comb begin
    state_d       = state_q;
    rst_cnt_d     = rst_cnt_q;
    cycle_count_d = cycle_count_q;
    stall_cnt_d   = stall_cnt_q;
    prev_pc_d     = prev_pc_q;
    prev_valid_d  = prev_valid_q;
    status_d      = status_q;

    if (enabled) begin
      cycle_count_d = cnt_inc;
      stall_cnt_d   = stall_inc;
      prev_pc_d     = bus.PC;
      prev_valid_d  = 1'b1;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.START) begin
          state_d       = S_RST_HOLD;
          rst_cnt_d     = RCW'(RST_CYCLES - 1);
          cycle_count_d = '0;
          stall_cnt_d   = '0;
          prev_valid_d  = 1'b0;
          status_d      = ST_NONE;
        end
      end
      S_RST_HOLD: begin
        if (rst_cnt_q == '0) begin
          state_d = bus.STEP_MODE ? S_STEP_WAIT : S_RUN;
        end else begin
          rst_cnt_d = rst_cnt_q - RCW'(1);
        end
      end
      S_RUN:       state_d = bus.STEP_MODE ? S_STEP_WAIT : S_RUN;
      S_STEP_WAIT: if (bus.STEP) state_d = S_STEP_EXEC;
      S_STEP_EXEC: state_d = bus.STEP_MODE ? S_STEP_WAIT : S_RUN;
      default:     state_d = S_IDLE;
    endcase

    // Termination overrides any mode transition; abort also fires on idle step cycles.
    if (is_abort) begin
      state_d  = S_DONE;
      status_d = ST_ABORT;
    end else if (enabled && (is_halt || is_max || is_hang)) begin
      state_d  = S_DONE;
      status_d = is_halt ? ST_HALT : (is_max ? ST_MAX : ST_HANG);
    end

    cpu_en_d    = (state_d == S_RUN) || (state_d == S_STEP_EXEC);
    cpu_rst_n_d = (state_d != S_IDLE) && (state_d != S_RST_HOLD);
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q       <= S_IDLE;
      rst_cnt_q     <= '0;
      cycle_count_q <= '0;
      stall_cnt_q   <= '0;
      prev_pc_q     <= '0;
      prev_valid_q  <= 1'b0;
      status_q      <= ST_NONE;
      cpu_en_q      <= 1'b0;
      cpu_rst_n_q   <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      cycle_count_q <= cycle_count_d;
      stall_cnt_q   <= stall_cnt_d;
      prev_pc_q     <= prev_pc_d;
      prev_valid_q  <= prev_valid_d;
      status_q      <= status_d;
      cpu_en_q      <= cpu_en_d;
      cpu_rst_n_q   <= cpu_rst_n_d;
      done_q        <= done_d;
    end
  end

  assign bus.CPU_EN      = cpu_en_q;
  assign bus.CPU_RST_N   = cpu_rst_n_q;
  assign bus.CYCLE_COUNT = cycle_count_q;
  assign bus.DONE        = done_q;
  assign bus.STATUS      = status_q;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Bench for cpu_run_controller: random instruction/PC streams per run, expected
// outcome and CPU_RST_N/CPU_EN/DONE trace derived from the run-control rules.
module tb_cpu_run_controller;
  localparam int          PCW   = 64;
  localparam int          ICW   = 32;
  localparam int          CW    = 32;
  localparam int          MAX   = 12;
  localparam int          STALL = 8;
  localparam int          RSTC  = 2;
  localparam logic [31:0] HALT  = 32'hD4400000;
  localparam int          N     = 64;

  logic clk;
  logic rst_n;

  cpu_run_controller_if #(.PC_WIDTH(PCW), .IC_WIDTH(ICW), .CNT_WIDTH(CW)) bus ();

  cpu_run_controller #(
    .PC_WIDTH(PCW), .IC_WIDTH(ICW), .CNT_WIDTH(CW), .MAX_CYCLES(MAX),
    .HALT_OPCODE(HALT), .STALL_LIMIT(STALL), .RST_CYCLES(RSTC)
  ) dut (
    .CLOCK(clk),
    .RESET_N(rst_n),
    .bus(bus)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int          checks = 0;
  int          passes = 0;
  logic [2:0]  exp_q[$];
  logic [2:0]  obs_q[$];
  logic [63:0] pc_arr[N];
  logic [31:0] ic_arr[N];
  int          abort_at;
  logic        timed_out;
  logic [31:0] snap_count, fin_count;
  logic [2:0]  snap_status, fin_status;
  logic        snap_done;
  int          exp_cnt;
  logic [2:0]  exp_st;

  function automatic logic [31:0] rand_ic();
    logic [31:0] v;
    v = $urandom;
    if (v == HALT) v = v ^ 32'h1;
    return v;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < N; i++) begin
      ic_arr[i] = rand_ic();
      pc_arr[i] = {$urandom, $urandom};
    end
    abort_at = -1;
  endtask

  // Reference: walk the enabled cycles of the stream and find the first end condition.
  function automatic void model_run(output int cnt, output logic [2:0] st);
    int run;
    run = 0;
    cnt = 0;
    st  = 3'd0;
    for (int c = 1; c <= N; c++) begin
      if (c >= 2 && pc_arr[c-1] == pc_arr[c-2]) run++;
      else run = 0;
      if (c - 1 == abort_at)                st = 3'd4;
      else if (ic_arr[c-1] == HALT)         st = 3'd1;
      else if (c == MAX)                    st = 3'd2;
      else if (STALL != 0 && run == STALL)  st = 3'd3;
      if (st != 3'd0) begin
        cnt = c;
        return;
      end
    end
  endfunction

  // Expected {CPU_RST_N, CPU_EN, DONE} per cycle from the first RST_HOLD cycle to DONE.
  task automatic build_exp(input int cnt);
    exp_q.delete();
    obs_q.delete();
    repeat (RSTC) exp_q.push_back(3'b000);
    repeat (cnt)  exp_q.push_back(3'b110);
    exp_q.push_back(3'b101);
  endtask

  // driver tasks
  task automatic do_start();
    bus.START = 1'b1;
    @(posedge clk); #1;
    bus.START = 1'b0;
  endtask

  // Behaves like the core: presents ic/pc_arr[n] on the n-th enabled cycle.
  // Disabled cycles carry a HLT word and ABORT is raised during core reset hold.
  task automatic run_free();
    int n;
    int idx;
    n = 0;
    timed_out = 1'b1;
    bus.STEP_MODE = 1'b0;
    do_start();
    snap_count  = bus.CYCLE_COUNT;
    snap_status = bus.STATUS;
    snap_done   = bus.DONE;
    for (int t = 0; t < 200; t++) begin
      obs_q.push_back({bus.CPU_RST_N, bus.CPU_EN, bus.DONE});
      if (bus.DONE) begin
        fin_count  = bus.CYCLE_COUNT;
        fin_status = bus.STATUS;
        timed_out  = 1'b0;
        break;
      end
      if (bus.CPU_EN) begin
        idx       = (n < N) ? n : N - 1;
        bus.IC    = ic_arr[idx];
        bus.PC    = pc_arr[idx];
        bus.ABORT = (n == abort_at);
        bus.START = (n == 1);
        n++;
      end else begin
        bus.IC    = HALT;
        bus.PC    = {$urandom, $urandom};
        bus.ABORT = !bus.CPU_RST_N;
        bus.START = 1'b0;
      end
      @(posedge clk); #1;
    end
    bus.ABORT = 1'b0;
    bus.START = 1'b0;
  endtask

  // tests
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.CPU_EN !== 1'b0) $display("FAIL reset_cpu_en got %b expected 0", bus.CPU_EN); else passes++;
    checks++; if (bus.CPU_RST_N !== 1'b0) $display("FAIL reset_cpu_rst_n got %b expected 0", bus.CPU_RST_N); else passes++;
    checks++; if (bus.CYCLE_COUNT !== 32'd0) $display("FAIL reset_count got %0d expected 0", bus.CYCLE_COUNT); else passes++;
    checks++; if (bus.DONE !== 1'b0) $display("FAIL reset_done got %b expected 0", bus.DONE); else passes++;
    checks++; if (bus.STATUS !== 3'd0) $display("FAIL reset_status got %0d expected 0", bus.STATUS); else passes++;
    checks++; if (bus.dbg_state !== 3'd0) $display("FAIL reset_state got %0d expected 0", bus.dbg_state); else passes++;
    @(posedge clk); #2;
    rst_n = 1'b1;
    bus.ABORT = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.ABORT = 1'b0;
    checks++; if ({bus.CPU_RST_N, bus.CPU_EN, bus.DONE, bus.STATUS} !== 6'b000000)
      $display("FAIL idle_abort_ignored got %b expected 000000", {bus.CPU_RST_N, bus.CPU_EN, bus.DONE, bus.STATUS});
    else passes++;
  endtask

  task automatic test_max_budget();
    fill_random();
    model_run(exp_cnt, exp_st);
    build_exp(exp_cnt);
    run_free();
    checks++; if (timed_out !== 1'b0) $display("FAIL max_timeout got %b expected 0", timed_out); else passes++;
    checks++; if (snap_count !== 32'd0) $display("FAIL max_start_count got %0d expected 0", snap_count); else passes++;
    checks++; if (fin_count !== 32'(exp_cnt)) $display("FAIL max_count got %0d expected %0d", fin_count, exp_cnt); else passes++;
    checks++; if (fin_status !== exp_st) $display("FAIL max_status got %0d expected %0d", fin_status, exp_st); else passes++;
    while (exp_q.size() > 0) begin
      logic [2:0] e, o;
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 3'bxxx;
      checks++; if (o !== e) $display("FAIL max_trace rst_n/en/done got %b expected %b", o, e); else passes++;
    end
    // DONE holds with ABORT asserted and no START
    bus.ABORT = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    bus.ABORT = 1'b0;
    checks++; if ({bus.CPU_RST_N, bus.CPU_EN, bus.DONE} !== 3'b101)
      $display("FAIL done_hold got %b expected 101", {bus.CPU_RST_N, bus.CPU_EN, bus.DONE}); else passes++;
    checks++; if (bus.STATUS !== exp_st) $display("FAIL done_hold_status got %0d expected %0d", bus.STATUS, exp_st); else passes++;
    checks++; if (bus.CYCLE_COUNT !== 32'(exp_cnt)) $display("FAIL done_hold_count got %0d expected %0d", bus.CYCLE_COUNT, exp_cnt); else passes++;
  endtask

  task automatic test_halt();
    for (int k = 0; k < 4; k++) begin
      int h;
      fill_random();
      h = (k == 0) ? 3 : ((k == 1) ? MAX : $urandom_range(1, MAX));
      ic_arr[h-1] = HALT;
      model_run(exp_cnt, exp_st);
      build_exp(exp_cnt);
      run_free();
      checks++; if (timed_out !== 1'b0) $display("FAIL halt_timeout got %b expected 0", timed_out); else passes++;
      checks++; if (fin_count !== 32'(exp_cnt)) $display("FAIL halt_count got %0d expected %0d", fin_count, exp_cnt); else passes++;
      checks++; if (fin_status !== exp_st) $display("FAIL halt_status got %0d expected %0d", fin_status, exp_st); else passes++;
      while (exp_q.size() > 0) begin
        logic [2:0] e, o;
        e = exp_q.pop_front();
        o = (obs_q.size() > 0) ? obs_q.pop_front() : 3'bxxx;
        checks++; if (o !== e) $display("FAIL halt_trace rst_n/en/done got %b expected %b", o, e); else passes++;
      end
    end
  endtask

  task automatic test_hang();
    for (int k = 0; k < 3; k++) begin
      int f;
      fill_random();
      f = (k == 0) ? 1 : ((k == 1) ? 3 : $urandom_range(0, 2));
      for (int i = f; i < N; i++) pc_arr[i] = 64'h40;
      model_run(exp_cnt, exp_st);
      build_exp(exp_cnt);
      run_free();
      checks++; if (timed_out !== 1'b0) $display("FAIL hang_timeout got %b expected 0", timed_out); else passes++;
      checks++; if (fin_count !== 32'(exp_cnt)) $display("FAIL hang_count got %0d expected %0d", fin_count, exp_cnt); else passes++;
      checks++; if (fin_status !== exp_st) $display("FAIL hang_status got %0d expected %0d", fin_status, exp_st); else passes++;
      while (exp_q.size() > 0) begin
        logic [2:0] e, o;
        e = exp_q.pop_front();
        o = (obs_q.size() > 0) ? obs_q.pop_front() : 3'bxxx;
        checks++; if (o !== e) $display("FAIL hang_trace rst_n/en/done got %b expected %b", o, e); else passes++;
      end
    end
  endtask

  // Steps at post-hold cycles 1, 5, 9; the pulse at 2 lands in the execute cycle and is
  // dropped; a step with STEP_MODE=0 at 12 resumes free-run until the budget ends it.
  task automatic test_step();
    logic finished;
    finished = 1'b0;
    bus.STEP_MODE = 1'b1;
    bus.ABORT     = 1'b0;
    do_start();
    for (int t = 0; t < 60; t++) begin
      int j;
      logic [2:0] e, o;
      j = t - RSTC;
      if (t < RSTC) e = 3'b000;
      else if (j >= 22) e = 3'b101;
      else e = {1'b1, (j == 2 || j == 6 || j == 10 || (j >= 13 && j <= 21)), 1'b0};
      o = {bus.CPU_RST_N, bus.CPU_EN, bus.DONE};
      checks++; if (o !== e) $display("FAIL step_trace cycle %0d rst_n/en/done got %b expected %b", j, o, e); else passes++;
      if (j == 11) begin
        checks++; if (bus.CYCLE_COUNT !== 32'd3) $display("FAIL step_count got %0d expected 3", bus.CYCLE_COUNT); else passes++;
      end
      if (bus.DONE) begin
        finished = 1'b1;
        checks++; if (bus.CYCLE_COUNT !== 32'(MAX)) $display("FAIL step_final_count got %0d expected %0d", bus.CYCLE_COUNT, MAX); else passes++;
        checks++; if (bus.STATUS !== 3'd2) $display("FAIL step_final_status got %0d expected 2", bus.STATUS); else passes++;
        break;
      end
      bus.STEP      = (j == 1 || j == 2 || j == 5 || j == 9 || j == 12);
      bus.STEP_MODE = (j < 12);
      bus.IC        = bus.CPU_EN ? rand_ic() : HALT;
      bus.PC        = 64'h1000 + 64'(t * 4);
      @(posedge clk); #1;
    end
    bus.STEP      = 1'b0;
    bus.STEP_MODE = 1'b0;
    checks++; if (finished !== 1'b1) $display("FAIL step_timeout got %b expected 1", finished); else passes++;
  endtask

  task automatic test_abort_halt();
    int h;
    fill_random();
    h = $urandom_range(2, MAX - 1);
    ic_arr[h-1] = HALT;
    abort_at = h - 1;
    model_run(exp_cnt, exp_st);
    build_exp(exp_cnt);
    run_free();
    checks++; if (timed_out !== 1'b0) $display("FAIL abort_timeout got %b expected 0", timed_out); else passes++;
    checks++; if (fin_status !== 3'd4) $display("FAIL abort_halt_status got %0d expected 4", fin_status); else passes++;
    checks++; if (fin_count !== 32'(h)) $display("FAIL abort_halt_count got %0d expected %0d", fin_count, h); else passes++;
    while (exp_q.size() > 0) begin
      logic [2:0] e, o;
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 3'bxxx;
      checks++; if (o !== e) $display("FAIL abort_trace rst_n/en/done got %b expected %b", o, e); else passes++;
    end
    // restart from DONE
    fill_random();
    abort_at = $urandom_range(0, MAX - 2);
    model_run(exp_cnt, exp_st);
    run_free();
    checks++; if (snap_count !== 32'd0) $display("FAIL restart_count got %0d expected 0", snap_count); else passes++;
    checks++; if (snap_done !== 1'b0) $display("FAIL restart_done got %b expected 0", snap_done); else passes++;
    checks++; if (snap_status !== 3'd0) $display("FAIL restart_status got %0d expected 0", snap_status); else passes++;
    checks++; if (fin_status !== exp_st) $display("FAIL restart_final_status got %0d expected %0d", fin_status, exp_st); else passes++;
    checks++; if (fin_count !== 32'(exp_cnt)) $display("FAIL restart_final_count got %0d expected %0d", fin_count, exp_cnt); else passes++;
  endtask

  task automatic test_async_reset();
    bus.STEP_MODE = 1'b0;
    bus.ABORT     = 1'b0;
    do_start();
    for (int k = 0; k < RSTC + 3; k++) begin
      bus.IC = rand_ic();
      bus.PC = {$urandom, $urandom};
      @(posedge clk); #1;
    end
    checks++; if (bus.CPU_EN !== 1'b1) $display("FAIL midrun_cpu_en got %b expected 1", bus.CPU_EN); else passes++;
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if ({bus.CPU_RST_N, bus.CPU_EN, bus.DONE} !== 3'b000)
      $display("FAIL async_reset_outputs got %b expected 000", {bus.CPU_RST_N, bus.CPU_EN, bus.DONE}); else passes++;
    checks++; if (bus.CYCLE_COUNT !== 32'd0) $display("FAIL async_reset_count got %0d expected 0", bus.CYCLE_COUNT); else passes++;
    checks++; if (bus.STATUS !== 3'd0) $display("FAIL async_reset_status got %0d expected 0", bus.STATUS); else passes++;
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    fill_random();
    ic_arr[3] = HALT;
    model_run(exp_cnt, exp_st);
    build_exp(exp_cnt);
    run_free();
    checks++; if (timed_out !== 1'b0) $display("FAIL post_reset_timeout got %b expected 0", timed_out); else passes++;
    checks++; if (fin_count !== 32'(exp_cnt)) $display("FAIL post_reset_count got %0d expected %0d", fin_count, exp_cnt); else passes++;
    checks++; if (fin_status !== exp_st) $display("FAIL post_reset_status got %0d expected %0d", fin_status, exp_st); else passes++;
    while (exp_q.size() > 0) begin
      logic [2:0] e, o;
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 3'bxxx;
      checks++; if (o !== e) $display("FAIL post_reset_trace rst_n/en/done got %b expected %b", o, e); else passes++;
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 6; k++) begin
      int r;
      fill_random();
      r = $urandom_range(0, 3);
      if (r == 1) ic_arr[$urandom_range(0, MAX - 1)] = HALT;
      if (r == 2) abort_at = $urandom_range(0, MAX - 1);
      if (r == 3) begin
        int f;
        f = $urandom_range(0, 3);
        for (int i = f; i < N; i++) pc_arr[i] = 64'h80;
      end
      model_run(exp_cnt, exp_st);
      build_exp(exp_cnt);
      run_free();
      checks++; if (timed_out !== 1'b0) $display("FAIL b2b_timeout got %b expected 0", timed_out); else passes++;
      checks++; if ({snap_done, snap_status, snap_count} !== 36'd0)
        $display("FAIL b2b_start_clear got %0h expected 0", {snap_done, snap_status, snap_count}); else passes++;
      checks++; if (fin_count !== 32'(exp_cnt)) $display("FAIL b2b_count got %0d expected %0d", fin_count, exp_cnt); else passes++;
      checks++; if (fin_status !== exp_st) $display("FAIL b2b_status got %0d expected %0d", fin_status, exp_st); else passes++;
      while (exp_q.size() > 0) begin
        logic [2:0] e, o;
        e = exp_q.pop_front();
        o = (obs_q.size() > 0) ? obs_q.pop_front() : 3'bxxx;
        checks++; if (o !== e) $display("FAIL b2b_trace rst_n/en/done got %b expected %b", o, e); else passes++;
      end
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.START     = 1'b0;
    bus.ABORT     = 1'b0;
    bus.STEP_MODE = 1'b0;
    bus.STEP      = 1'b0;
    bus.PC        = '0;
    bus.IC        = '0;
    abort_at      = -1;
    test_reset();
    test_max_budget();
    test_halt();
    test_hang();
    test_step();
    test_abort_halt();
    test_async_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
